// File: rtl/umi_arbiter_if.sv
// umi_arbiter_if: request/grant bundle between crossbar requesters and one output arbiter
interface umi_arbiter_if #(parameter int N = 4);
    logic [1:0]   mode;
    logic [N-1:0] mask;
    logic [N-1:0] requests;
    logic [N-1:0] eom;
    logic         out_ready;
    logic [N-1:0] grants;
    logic         out_valid;
    logic         locked;
    modport master (
        output mode, mask, requests, eom, out_ready,
        input  grants, out_valid, locked
    );
    modport slave (
        input  mode, mask, requests, eom, out_ready,
        output grants, out_valid, locked
    );
endinterface

// File: rtl/umi_arbiter.sv
// umi_arbiter: fixed-priority / round-robin output arbiter with packet lock
module umi_arbiter #(
    parameter int N = 4
) (
    input logic        clk,
    input logic        nreset,
    umi_arbiter_if.slave bus
);
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    state_t         state, state_nxt;
    logic [N-1:0]   ptr, ptr_nxt, owner, owner_nxt;
    logic [N-1:0]   eligible, fix_gnt, rr_gnt, gnt;
    logic [2*N-1:0] rr_dbl, rr_sel;
    logic           accept, eom_hit;
    // grant selection: lowest eligible bit, or first eligible at/above ptr via a doubled vector
    always_comb begin
        eligible = bus.requests & ~bus.mask;
        fix_gnt  = eligible & (~eligible + N'(1));
        rr_dbl   = {eligible, eligible & ~(ptr - N'(1))};
        rr_sel   = rr_dbl & (~rr_dbl + (2*N)'(1));
        rr_gnt   = rr_sel[2*N-1:N] | rr_sel[N-1:0];
        gnt      = !nreset ? '0 : state == LOCKED ? owner : bus.mode == 2'b10 ? rr_gnt : fix_gnt;
    end
    assign bus.grants    = gnt;
    assign bus.out_valid = |(gnt & bus.requests);
    assign bus.locked    = state == LOCKED;
    assign accept        = bus.out_valid & bus.out_ready;
    assign eom_hit       = |(gnt & bus.eom);
    // next state: accepted non-eom beat locks onto the granted requester, eom releases and advances ptr
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        if (accept) begin
            state_nxt = eom_hit ? UNLOCKED : LOCKED;
            owner_nxt = eom_hit ? '0 : gnt;
            ptr_nxt   = eom_hit ? {gnt[N-2:0], gnt[N-1]} : ptr;
        end
    end
    // state registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= UNLOCKED;
            owner <= '0;
            ptr   <= N'(1);
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end
endmodule

// File: tb/tb_umi_arbiter.sv
// tb_umi_arbiter: directed vectors for umi_arbiter
module tb_umi_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic nreset;
    int   vectors = 0;
    int   miscompares = 0;
    umi_arbiter_if #(.N(N)) bus ();
    umi_arbiter #(.N(N)) dut (.clk(clk), .nreset(nreset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [N-1:0] exp;
        nreset = 1'b0;
        bus.mode = 2'b10;
        bus.mask = '0;
        bus.requests = 4'b1111;
        bus.eom = 4'b1111;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rst_grants", bus.grants, 4'b0000);
        check("rst_valid", N'(bus.out_valid), 4'b0000);
        check("rst_locked", N'(bus.locked), 4'b0000);
        tick;
        nreset = 1'b1;
        exp = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rr_rot%0d", i), bus.grants, exp);
            check($sformatf("rr_valid%0d", i), N'(bus.out_valid), 4'b0001);
            exp = {exp[N-2:0], exp[N-1]};
            tick;
        end
        bus.mode = 2'b00;
        bus.requests = 4'b1011;
        bus.mask = 4'b0001;
        @(negedge clk);
        check("fix_mask_a", bus.grants, 4'b0010);
        tick;
        @(negedge clk);
        check("fix_mask_b", bus.grants, 4'b0010);
        tick;
        bus.mask = 4'b0000;
        @(negedge clk);
        check("fix_nomask", bus.grants, 4'b0001);
        bus.mode = 2'b11;
        @(negedge clk);
        check("mode11_fixed", bus.grants, 4'b0001);
        tick;
        nreset = 1'b0;
        tick;
        nreset = 1'b1;
        bus.mode = 2'b10;
        bus.requests = 4'b0011;
        bus.eom = 4'b0000;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("lk_c1_gnt", bus.grants, 4'b0001);
        check("lk_c1_lock", N'(bus.locked), 4'b0000);
        tick;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("lk_c2_gnt", bus.grants, 4'b0001);
        check("lk_c2_lock", N'(bus.locked), 4'b0001);
        tick;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("lk_c3_gnt", bus.grants, 4'b0001);
        check("lk_c3_lock", N'(bus.locked), 4'b0001);
        tick;
        bus.eom = 4'b0001;
        @(negedge clk);
        check("lk_c4_gnt", bus.grants, 4'b0001);
        check("lk_c4_lock", N'(bus.locked), 4'b0001);
        tick;
        bus.eom = 4'b0000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("lk_c5_gnt", bus.grants, 4'b0010);
        check("lk_c5_lock", N'(bus.locked), 4'b0000);
        check("lk_c5_valid", N'(bus.out_valid), 4'b0001);
        tick;
        bus.requests = 4'b0100;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("ml_first", bus.grants, 4'b0100);
        tick;
        bus.mask = 4'b0100;
        bus.mode = 2'b00;
        bus.requests = 4'b0111;
        @(negedge clk);
        check("ml_held_a", bus.grants, 4'b0100);
        check("ml_locked", N'(bus.locked), 4'b0001);
        tick;
        @(negedge clk);
        check("ml_held_b", bus.grants, 4'b0100);
        bus.eom = 4'b0100;
        tick;
        bus.eom = 4'b0000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("ml_release", bus.grants, 4'b0001);
        check("ml_unlocked", N'(bus.locked), 4'b0000);
        tick;
        bus.mode = 2'b10;
        bus.mask = 4'b0000;
        bus.requests = 4'b0010;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rm_gnt", bus.grants, 4'b0010);
        tick;
        @(negedge clk);
        check("rm_locked", N'(bus.locked), 4'b0001);
        nreset = 1'b0;
        #1;
        check("rm_rst_gnt", bus.grants, 4'b0000);
        check("rm_rst_lock", N'(bus.locked), 4'b0000);
        check("rm_rst_valid", N'(bus.out_valid), 4'b0000);
        tick;
        nreset = 1'b1;
        bus.requests = 4'b0110;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("rm_after", bus.grants, 4'b0010);
        bus.requests = 4'b1100;
        #1;
        check("rm_ptr0", bus.grants, 4'b0100);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
